// File: rtl/mem_bus_ctrl_pkg.sv
// Shared dbus types for the MEM stage controller.
// Request/response bundles and access-size encoding.
package mem_bus_ctrl_pkg;

  typedef logic [63:0] data_addr_t;
  typedef logic [63:0] data_data_t;
  typedef logic [7:0]  data_strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic         valid;
    data_addr_t   addr;
    msize_t       size;
    data_strobe_t strobe;
    data_data_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic       addr_ok;
    logic       data_ok;
    data_data_t data;
  } dbus_resp_t;

endpackage

// File: rtl/mem_bus_ctrl_align.sv
// Natural-alignment check for a dbus access.
// Only the low address bits matter for any size.
module mem_align_check
  import mem_bus_ctrl_pkg::*;
(
  input  logic [2:0] addr_lo,
  input  msize_t     size,
  output logic       mis
);

  always_comb begin
    mis = 1'b0;
    unique case (size)
      MSIZE1:  mis = 1'b0;
      MSIZE2:  mis = addr_lo[0];
      MSIZE4:  mis = |addr_lo[1:0];
      MSIZE8:  mis = |addr_lo[2:0];
      default: mis = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage dbus controller: one outstanding access,
// pipeline stall while in flight, wrong-path discard.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             mem_read,
  input  logic             mem_write,
  input  dbus_req_t        req_in,
  input  logic             flush,
  input  logic             out_ready,
  output dbus_req_t        dreq,
  input  dbus_resp_t       dresp,
  output data_data_t       raw_data,
  output logic             out_valid,
  output logic             misalign,
  output logic             stall,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  dbus_req_t  req_q;
  data_data_t data_q;
  logic       discard_q;

  logic is_mem;
  logic mis;
  logic idle_take;
  logic accept;
  logic pass_thru;
  logic busy;
  logic hold;
  logic unused_ok;

  mem_align_check u_align (
    .addr_lo (req_in.addr[2:0]),
    .size    (req_in.size),
    .mis     (mis)
  );

  assign is_mem    = mem_read | mem_write;
  assign busy      = (state == BUSY);
  assign hold      = (state == HOLD);
  assign idle_take = (state == IDLE) & in_valid & ~flush;
  assign accept    = idle_take & is_mem & ~mis;
  assign pass_thru = idle_take & ~accept;

  // addr_ok never releases the request; only data_ok does
  assign unused_ok = dresp.addr_ok ^ req_q.valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= '0;
      data_q    <= '0;
      discard_q <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_q     <= req_in;
            wait_cnt  <= '0;
            discard_q <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt != '1)
            wait_cnt <= wait_cnt + CNT_ONE;
          if (flush)
            discard_q <= 1'b1;
          if (dresp.data_ok) begin
            data_q    <= dresp.data;
            discard_q <= 1'b0;
            state     <= (discard_q | flush) ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (out_ready | flush)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dreq       = req_q;
    dreq.valid = busy;
  end

  assign raw_data = data_q;

  always_comb begin
    out_valid = 1'b0;
    misalign  = 1'b0;
    stall     = 1'b0;
    unique case (1'b1)
      busy: stall = 1'b1;
      hold: begin
        out_valid = ~flush;
        stall     = ~out_ready & ~flush;
      end
      accept: stall = 1'b1;
      pass_thru: begin
        out_valid = 1'b1;
        misalign  = is_mem & mis;
        stall     = ~out_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed loads,
// stores, misalign, flush, backpressure and reset.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_read, mem_write;
  logic        flush, out_ready;
  dbus_req_t   req_in, dreq;
  dbus_resp_t  dresp;
  data_data_t  raw_data;
  logic        out_valid, misalign, stall;
  logic [15:0] wait_cnt;

  typedef struct {
    logic       mis;
    logic       chk;
    data_data_t data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_bus_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .req_in    (req_in),
    .flush     (flush),
    .out_ready (out_ready),
    .dreq      (dreq),
    .dresp     (dresp),
    .raw_data  (raw_data),
    .out_valid (out_valid),
    .misalign  (misalign),
    .stall     (stall),
    .wait_cnt  (wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    flush     = 1'b0;
    dresp     = '0;
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [63:0] a, input msize_t sz,
                       input logic [7:0] stb, input logic [63:0] d);
    in_valid      = 1'b1;
    mem_read      = rd;
    mem_write     = wr;
    req_in        = '0;
    req_in.addr   = a;
    req_in.size   = sz;
    req_in.strobe = stb;
    req_in.data   = d;
  endtask

  task automatic push(input logic m, input logic c,
                      input logic [63:0] d);
    exp_t e;
    e.mis  = m;
    e.chk  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: pop on every accepted result
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got out_valid=1 want none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_misalign", 64'(misalign), 64'(e.mis));
        if (e.chk)
          chk("mon_raw_data", raw_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  int rises;
  logic prev_v;

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    req_in    = '0;
    idle_in();
    @(negedge clk);
    chk("rst_dreq_valid", 64'(dreq.valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_wait_cnt", 64'(wait_cnt), 64'd0);
    tick();
    reset = 1'b0;

    // aligned load, data_ok at cycle 4
    tick();
    issue(1, 0, 64'h1000, MSIZE8, 8'hFF, 64'h0);
    push(0, 1, 64'hDEADBEEF_01234567);
    @(negedge clk);
    chk("ld_c0_stall", 64'(stall), 64'd1);
    chk("ld_c0_dreq", 64'(dreq.valid), 64'd0);
    tick();
    idle_in();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hDEADBEEF_01234567;
      end
      @(negedge clk);
      chk("ld_dreq_valid", 64'(dreq.valid), 64'd1);
      chk("ld_stall", 64'(stall), 64'd1);
      chk("ld_dreq_addr", dreq.addr, 64'h1000);
      if (c == 4)
        chk("ld_raw_noglitch", raw_data, 64'h0);
      tick();
    end
    dresp = '0;
    @(negedge clk);
    chk("ld_c5_out_valid", 64'(out_valid), 64'd1);
    chk("ld_c5_stall", 64'(stall), 64'd0);
    chk("ld_c5_dreq", 64'(dreq.valid), 64'd0);
    chk("ld_wait_cnt", 64'(wait_cnt), 64'd4);
    tick();

    // store, data_ok at cycle 3
    rises  = 0;
    prev_v = 1'b0;
    issue(0, 1, 64'h2004, MSIZE4, 8'hF0, 64'h11223344_55667788);
    push(0, 0, 64'h0);
    for (int c = 0; c <= 5; c++) begin
      if (c == 1) idle_in();
      if (c == 3) dresp.data_ok = 1'b1;
      if (c == 4) dresp = '0;
      @(negedge clk);
      if (dreq.valid && !prev_v) rises++;
      prev_v = dreq.valid;
      if (c >= 1 && c <= 3) begin
        chk("st_addr", dreq.addr, 64'h2004);
        chk("st_strobe", 64'(dreq.strobe), 64'hF0);
        chk("st_data", dreq.data, 64'h11223344_55667788);
        chk("st_size", 64'(dreq.size), 64'(MSIZE4));
      end
      if (c == 4)
        chk("st_out_valid", 64'(out_valid), 64'd1);
      tick();
    end
    chk("st_req_once", 64'(rises), 64'd1);

    // misaligned halfword load
    issue(1, 0, 64'h3001, MSIZE2, 8'h03, 64'h0);
    push(1, 0, 64'h0);
    @(negedge clk);
    chk("mis_misalign", 64'(misalign), 64'd1);
    chk("mis_out_valid", 64'(out_valid), 64'd1);
    chk("mis_dreq", 64'(dreq.valid), 64'd0);
    chk("mis_stall", 64'(stall), 64'd0);
    tick();
    idle_in();
    @(negedge clk);
    chk("mis_dreq_after", 64'(dreq.valid), 64'd0);
    tick();

    // flush one cycle after accept
    issue(1, 0, 64'h4000, MSIZE8, 8'hFF, 64'h0);
    @(negedge clk);
    chk("fl_c0_stall", 64'(stall), 64'd1);
    tick();
    idle_in();
    flush = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) flush = 1'b0;
      if (c == 3) begin
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hBAD0BAD0_BAD0BAD0;
      end
      @(negedge clk);
      chk("fl_dreq_held", 64'(dreq.valid), 64'd1);
      chk("fl_addr", dreq.addr, 64'h4000);
      tick();
    end
    dresp = '0;
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk);
      chk("fl_no_out", 64'(out_valid), 64'd0);
      chk("fl_idle_stall", 64'(stall), 64'd0);
      tick();
    end

    // backpressure in HOLD, minimum latency
    out_ready = 1'b0;
    issue(1, 0, 64'h5008, MSIZE8, 8'hFF, 64'h0);
    push(0, 1, 64'hCAFEF00D_12345678);
    tick();
    idle_in();
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hCAFEF00D_12345678;
    @(negedge clk);
    chk("hp_c1_dreq", 64'(dreq.valid), 64'd1);
    tick();
    dresp = '0;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      chk("hp_out_valid", 64'(out_valid), 64'd1);
      chk("hp_stall", 64'(stall), 64'd1);
      chk("hp_raw", raw_data, 64'hCAFEF00D_12345678);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hp_rel_valid", 64'(out_valid), 64'd1);
    chk("hp_rel_stall", 64'(stall), 64'd0);
    tick();
    @(negedge clk);
    chk("hp_after", 64'(out_valid), 64'd0);
    tick();

    // reset mid-BUSY
    issue(1, 0, 64'h6000, MSIZE8, 8'hFF, 64'h0);
    tick();
    idle_in();
    tick();
    @(negedge clk);
    chk("rb_busy", 64'(dreq.valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rb_async_dreq", 64'(dreq.valid), 64'd0);
    chk("rb_async_stall", 64'(stall), 64'd0);
    chk("rb_async_cnt", 64'(wait_cnt), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    issue(1, 0, 64'h6010, MSIZE8, 8'hFF, 64'h0);
    push(0, 1, 64'h0F0F0F0F_F0F0F0F0);
    tick();
    idle_in();
    tick();
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h0F0F0F0F_F0F0F0F0;
    @(negedge clk);
    chk("rb2_dreq", 64'(dreq.valid), 64'd1);
    tick();
    dresp = '0;
    @(negedge clk);
    chk("rb2_out_valid", 64'(out_valid), 64'd1);
    chk("rb2_wait_cnt", 64'(wait_cnt), 64'd2);
    tick();
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
